// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store stage.
//   - funct3 access size/sign codes (F3_*)
//   - FSM state type for memory_access
//   - helpers for access-size decode, misalignment and offset alignment
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_t;

   // funct3[1:0] selects the size; 11 (and therefore 011/110/111) is a word.
   function automatic size_t access_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (access_size(f3))
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Snap the byte offset down to the natural alignment of the access size.
   function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
      case (access_size(f3))
         SZ_H:    return {off[1], 1'b0};
         SZ_W:    return 2'b00;
         default: return off;
      endcase
   endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// load_extend: combinational load-data extraction.
//   rdata   - raw read word from data memory
//   offset  - byte offset of the access inside the word (already aligned)
//   funct3  - access size/sign code
//   ext     - byte/half/word shifted down and sign- or zero-extended
module load_extend
   import mem_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] ext
);

   logic [XLEN-1:0] shifted;
   logic            is_signed;

   always_comb begin
      shifted   = rdata >> {offset, 3'b000};
      is_signed = ~funct3[2];
      ext       = shifted;
      case (access_size(funct3))
         SZ_B:    ext = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
         SZ_H:    ext = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// memory_access: load/store stage of the non-pipelined core.
// Runs one handshaked transaction on the data-memory port per start, then
// pulses done (with extended load data for loads).
//   start/mem_read/mem_write/funct3/addr/store_data : request, sampled in IDLE
//   busy, done, load_data, misaligned_err           : status/result to core
//   dmem_req/we/addr/wdata/be, dmem_ready           : request channel
//   dmem_rvalid/rdata                               : read response channel
// Build option: MEM_MISALIGN_TRAP_EN - misaligned H/W accesses skip the bus
// and complete with misaligned_err; otherwise the offset is forced to
// natural alignment and misaligned_err is tied to 0.
module memory_access
   import mem_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned_err,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [2:0]      f3_q, f3_d;
   logic            wr_q, wr_d;
   logic [XLEN-1:0] sdata_q, sdata_d;
   logic [XLEN-1:0] ld_q, ld_d;
`ifdef MEM_MISALIGN_TRAP_EN
   logic            err_q, err_d;
`endif

   logic [1:0]      offset;
   logic [XLEN-1:0] ext_word;
   logic [XLEN-1:0] wdata_lanes;
   logic [3:0]      be_lanes;

   assign offset = align_offset(f3_q, addr_q[1:0]);

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .rdata  (dmem_rdata),
      .offset (offset),
      .funct3 (f3_q),
      .ext    (ext_word)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      wr_d    = wr_q;
      sdata_d = sdata_q;
      ld_d    = ld_q;
`ifdef MEM_MISALIGN_TRAP_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = addr;
               f3_d    = funct3;
               wr_d    = mem_write;
               sdata_d = store_data;
`ifdef MEM_MISALIGN_TRAP_EN
               err_d   = 1'b0;
`endif
               if (!(mem_read || mem_write)) begin
                  state_d = DONE;
               end else begin
                  state_d = REQ;
`ifdef MEM_MISALIGN_TRAP_EN
                  if (is_misaligned(funct3, addr[1:0])) begin
                     err_d   = 1'b1;
                     state_d = DONE;
                  end
`endif
               end
            end
         end
         REQ: begin
            if (dmem_ready) state_d = wr_q ? DONE : WAIT_RSP;
         end
         WAIT_RSP: begin
            if (dmem_rvalid) begin
               ld_d    = ext_word;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         wr_q    <= 1'b0;
         sdata_q <= '0;
         ld_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         wr_q    <= wr_d;
         sdata_q <= sdata_d;
         ld_q    <= ld_d;
`ifdef MEM_MISALIGN_TRAP_EN
         err_q   <= err_d;
`endif
      end
   end

   // Store lane replication and byte enables from the aligned offset.
   always_comb begin
      wdata_lanes = sdata_q;
      be_lanes    = 4'b1111;
      case (access_size(f3_q))
         SZ_B: begin
            wdata_lanes = {4{sdata_q[7:0]}};
            be_lanes    = 4'b0001 << offset;
         end
         SZ_H: begin
            wdata_lanes = {2{sdata_q[15:0]}};
            be_lanes    = 4'b0011 << offset;
         end
         default: begin
            wdata_lanes = sdata_q;
            be_lanes    = 4'b1111;
         end
      endcase
   end

   // Bus outputs are gated by the REQ state so reset clears them immediately.
   always_comb begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = '0;
      if (state_q == REQ) begin
         dmem_req   = 1'b1;
         dmem_we    = wr_q;
         dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
         dmem_wdata = wdata_lanes;
         dmem_be    = be_lanes;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign load_data = ld_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned_err = (state_q == DONE) && err_q;
`else
   assign misaligned_err = 1'b0;
`endif

endmodule

// File: doc/memory_access.md
# memory_access

Load/store stage of the non-pipelined core. It consumes the execution stage's ALU result as the effective address and its propagated second-register value as store data. It runs one handshaked transaction on the data-memory port, then returns sign- or zero-extended load data to writeback. It is multi-cycle; the core controller holds the instruction until `done`.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported (4 byte lanes).
- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request from controller; sampled only in IDLE.
- `mem_read`  in  1  instruction is a load.
- `mem_write`  in  1  instruction is a store; never set together with `mem_read`.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  XLEN  effective address (ALU result).
- `store_data`  in  XLEN  rs2 value (second-register propagation).
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  XLEN  extended load result; valid while `done`.
- `misaligned_err`  out  1  pulses with `done` on a misaligned access (macro-dependent).
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  XLEN  word-aligned address (`addr` with [1:0] cleared).
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ready`  in  1  memory accepts the request this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  XLEN  read data word.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - On `start`, capture `addr`, `funct3`, `mem_read`, `mem_write`, `store_data`.
  - If neither read nor write, or the access is misaligned under the trap macro, go to DONE.
  - Otherwise go to REQ.
- REQ:
  - `dmem_req`=1, and `dmem_addr`, `dmem_we`, `dmem_wdata`, `dmem_be` are driven from the captured registers, stable until accepted.
  - On `dmem_ready`: a store goes to DONE; a load goes to WAIT_RSP.
- WAIT_RSP:
  - `dmem_req`=0.
  - On `dmem_rvalid`, register the extended load data and go to DONE.
  - `dmem_rvalid` is ignored in every state other than WAIT_RSP.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored outside IDLE.
- Store lanes, with o = addr[1:0]:
  - SB: wdata = 4 copies of byte, be = 0001<<o.
  - SH: wdata = 2 copies of half, be = 0011<<o.
  - SW: wdata = store_data, be = 1111.
  - `funct3[1:0]`=11 is treated as SW.
- Load extraction:
  - rdata >> (8*o), then take the low byte or half.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend.
  - Load `funct3` 011/110/111 is treated as LW.
- `load_data` holds its value until the next load completes. Store and no-op completions leave it unchanged.

## Timing
- Reset value of every output: 0. The FSM resets to IDLE.
- Asserting `rst` mid-transaction drops `dmem_req` immediately (asynchronous) and abandons the transaction; there is no `done`.
- Store with `dmem_ready` held high: `start` at cycle 0, `dmem_req` cycles 1, `done` cycle 2.
- Load with ready at cycle 1 and rvalid at cycle 2: `done` at cycle 3.
- Minimum latency: no-op 1 cycle, store 2 cycles, load 3 cycles. Wait states extend REQ and WAIT_RSP without bound.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - An H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, issues no bus request.
  - The FSM goes IDLE→DONE and `misaligned_err`=1 with `done`.
- Undefined:
  - `misaligned_err` is tied to 0.
  - The offset is forced to natural alignment (H: o[0]=0; W: o=00) and the access proceeds normally.

## Structure
- Package `mem_pkg`: `funct3` size/sign constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state typedef.
- Sub-module `load_extend`: combinational; inputs rdata, offset, funct3; output the extended word.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready immediate -> `dmem_addr` 0x100, be 1111, wdata 0xDEADBEEF, `done` at cycle 2.
- SB addr 0x103, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x12F0_3456, rvalid 2 cycles after accept -> `load_data` 0xFFFFFFF0. LBU same -> 0x000000F0. LHU addr 0x102 -> 0x000012F0.
- LW with `dmem_ready` low for 3 cycles -> `dmem_req` and `dmem_addr` stable throughout, `done` exactly once.
- LH addr 0x101 -> with macro: no `dmem_req`, `done`+`misaligned_err` at cycle 1. Without macro: bus access at 0x100 using offset 0.
- `rst` pulsed during WAIT_RSP -> all outputs 0 asynchronously, no `done`; a later `start` works normally.
